fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares the single write port of the team's synchronous FIFO between NUM_REQ producers. Each producer gets bounded bursts of up to MAX_BURST beats with valid/ready handshaking. The arbiter honours FIFO full back-pressure and freezes all traffic when the FIFO flags an error, until software clears it. It sits between the producer agents and the FIFO's write_en, data_in, full and error pins.

---
 rtl/fifo_wr_arbiter.sv | 111 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// with bounded bursts, full back-pressure and an error halt released by err_clr_i.
module fifo_wr_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 4,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W      = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          fifo_write_en_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_in_o,
  input  logic                          fifo_full_i,
  input  logic                          fifo_error_i,
  input  logic                          err_clr_i,
  output logic [ID_W-1:0]               grant_id_o,
  output logic                          busy_o,
  output logic                          halted_o
);

  typedef enum logic [1:0] {IDLE, GRANT, HALT} state_e;

  state_e            state_q;
  logic [ID_W-1:0]   owner_q;
  logic [ID_W-1:0]   lastOwner_q;
  logic [CNT_W-1:0]  beatCnt_q;
  logic [ID_W-1:0]   nextOwner_d;
  logic              inGrant;
  logic              ownerValid;
  logic              beat;
  logic [DATA_WIDTH-1:0] ownerData;
  logic [NUM_REQ-1:0]    reqReady;

  // Scan last_owner+1, +2, ... modulo NUM_REQ; works for non-power-of-two counts.
  always_comb begin
    int  idx;
    logic found;
    nextOwner_d = lastOwner_q;
    found       = 1'b0;
    idx         = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(lastOwner_q) + k) % NUM_REQ;
      if (!found && req_valid_i[idx]) begin
        nextOwner_d = idx[ID_W-1:0];
        found       = 1'b1;
      end
    end
  end

  assign inGrant    = (state_q == GRANT);
  assign ownerValid = req_valid_i[owner_q];
  assign ownerData  = req_data_i[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
  assign beat       = inGrant & ownerValid & ~fifo_full_i & ~fifo_error_i;

  always_comb begin
    reqReady = '0;
    if (beat) reqReady[owner_q] = 1'b1;
  end

  assign req_ready_o     = reqReady;
  assign fifo_write_en_o = beat;
  assign fifo_data_in_o  = inGrant ? ownerData : '0;
  assign grant_id_o      = inGrant ? owner_q : '0;
  assign busy_o          = inGrant;
  assign halted_o        = (state_q == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      lastOwner_q <= ID_W'(NUM_REQ - 1);
      beatCnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fifo_error_i) begin
            state_q <= HALT;
          end else if (|req_valid_i) begin
            owner_q   <= nextOwner_d;
            beatCnt_q <= '0;
            state_q   <= GRANT;
          end
        end
        GRANT: begin
          // The interrupted owner is recorded so the grant after err_clr moves on to the next producer.
          if (fifo_error_i) begin
            lastOwner_q <= owner_q;
            state_q     <= HALT;
          end else if (beat && beatCnt_q == CNT_W'(MAX_BURST - 1)) begin
            lastOwner_q <= owner_q;
            state_q     <= IDLE;
          end else if (!ownerValid) begin
            lastOwner_q <= owner_q;
            state_q     <= IDLE;
          end else if (beat) begin
            beatCnt_q <= beatCnt_q + CNT_W'(1);
          end
        end
        HALT: begin
          if (err_clr_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4).
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  reqValid;
  logic [7:0]  prodData [4];
  logic [31:0] reqData;
  logic [3:0]  reqReady;
  logic        fifoWriteEn;
  logic [7:0]  fifoDataIn;
  logic        fifoFull;
  logic        fifoError;
  logic        errClr;
  logic [1:0]  grantId;
  logic        busy;
  logic        halted;

  int checks;
  int errors;

  assign reqData = {prodData[3], prodData[2], prodData[1], prodData[0]};

  fifo_wr_arbiter #(
    .NUM_REQ   (4),
    .DATA_WIDTH(8),
    .MAX_BURST (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (reqValid),
    .req_data_i     (reqData),
    .req_ready_o    (reqReady),
    .fifo_write_en_o(fifoWriteEn),
    .fifo_data_in_o (fifoDataIn),
    .fifo_full_i    (fifoFull),
    .fifo_error_i   (fifoError),
    .err_clr_i      (errClr),
    .grant_id_o     (grantId),
    .busy_o         (busy),
    .halted_o       (halted)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Checks all outputs at the falling edge, then moves to just after the next rising edge.
  task automatic expectCycle(input string tag, input logic we, input logic [7:0] data,
                             input logic [3:0] ready, input logic [1:0] gid,
                             input logic bsy, input logic hlt);
    @(negedge clk);
    checkOutput({tag, ".we"},     32'(fifoWriteEn), 32'(we));
    checkOutput({tag, ".data"},   32'(fifoDataIn),  32'(data));
    checkOutput({tag, ".ready"},  32'(reqReady),    32'(ready));
    checkOutput({tag, ".gid"},    32'(grantId),     32'(gid));
    checkOutput({tag, ".busy"},   32'(busy),        32'(bsy));
    checkOutput({tag, ".halted"}, 32'(halted),      32'(hlt));
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    // Reset state
    expectCycle("reset", 0, 8'h00, 4'b0000, 2'd0, 0, 0);
    rst_n = 1'b1;

    // Single producer 2, long burst: 4 beats, bubble, 2 beats, valid drop
    reqValid    = 4'b0100;
    prodData[2] = 8'h10;
    expectCycle("t1.idle", 0, 8'h00, 4'b0000, 2'd0, 0, 0);
    for (int b = 0; b < 4; b++) begin
      expectCycle($sformatf("t1.beat%0d", b), 1, 8'(8'h10 + b), 4'b0100, 2'd2, 1, 0);
      prodData[2] = 8'(8'h11 + b);
    end
    expectCycle("t1.bubble", 0, 8'h00, 4'b0000, 2'd0, 0, 0);
    for (int b = 0; b < 2; b++) begin
      expectCycle($sformatf("t1.beat%0d", b + 4), 1, 8'(8'h14 + b), 4'b0100, 2'd2, 1, 0);
      prodData[2] = 8'(8'h15 + b);
    end
    reqValid = 4'b0000;
    expectCycle("t1.drop", 0, 8'h16, 4'b0000, 2'd2, 1, 0);
    expectCycle("t1.end", 0, 8'h00, 4'b0000, 2'd0, 0, 0);

    // Round robin from reset: owners 0,1,2,3,0 with 5 cycles per burst
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    reqValid = 4'b1111;
    for (int i = 0; i < 4; i++) prodData[i] = 8'(8'hA0 + i);
    for (int burst = 0; burst < 5; burst++) begin
      int o;
      o = burst % 4;
      expectCycle($sformatf("t2.b%0d.idle", burst), 0, 8'h00, 4'b0000, 2'd0, 0, 0);
      for (int k = 0; k < 4; k++)
        expectCycle($sformatf("t2.b%0d.k%0d", burst, k), 1, 8'(8'hA0 + o),
                    4'(1 << o), 2'(o), 1, 0);
    end

    // Back-pressure on the 2nd beat of producer 1
    prodData[1] = 8'h31;
    expectCycle("t3.idle", 0, 8'h00, 4'b0000, 2'd0, 0, 0);
    expectCycle("t3.beat0", 1, 8'h31, 4'b0010, 2'd1, 1, 0);
    prodData[1] = 8'h32;
    fifoFull    = 1'b1;
    for (int s = 0; s < 3; s++)
      expectCycle($sformatf("t3.stall%0d", s), 0, 8'h32, 4'b0000, 2'd1, 1, 0);
    fifoFull = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expectCycle($sformatf("t3.beat%0d", k + 1), 1, 8'(8'h32 + k), 4'b0010, 2'd1, 1, 0);
      prodData[1] = 8'(8'h33 + k);
    end

    // Error halt mid-burst of producer 2, then release
    expectCycle("t4.idle", 0, 8'h00, 4'b0000, 2'd0, 0, 0);
    expectCycle("t4.beat0", 1, 8'hA2, 4'b0100, 2'd2, 1, 0);
    fifoError = 1'b1;
    expectCycle("t4.err", 0, 8'hA2, 4'b0000, 2'd2, 1, 0);
    fifoError = 1'b0;
    for (int h = 0; h < 10; h++)
      expectCycle($sformatf("t4.halt%0d", h), 0, 8'h00, 4'b0000, 2'd0, 0, 1);
    errClr = 1'b1;
    expectCycle("t4.clr", 0, 8'h00, 4'b0000, 2'd0, 0, 1);
    errClr = 1'b0;
    expectCycle("t4.idle2", 0, 8'h00, 4'b0000, 2'd0, 0, 0);

    // Producer 3 granted next, drops valid after 2 beats, producer 0 follows
    expectCycle("t5.beat0", 1, 8'hA3, 4'b1000, 2'd3, 1, 0);
    expectCycle("t5.beat1", 1, 8'hA3, 4'b1000, 2'd3, 1, 0);
    reqValid[3] = 1'b0;
    expectCycle("t5.drop", 0, 8'hA3, 4'b0000, 2'd3, 1, 0);
    expectCycle("t5.idle", 0, 8'h00, 4'b0000, 2'd0, 0, 0);
    expectCycle("t5.next", 1, 8'hA0, 4'b0001, 2'd0, 1, 0);

    // Asynchronous reset between edges during producer 0's burst
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6.we",    32'(fifoWriteEn), 32'd0);
    checkOutput("t6.busy",  32'(busy),        32'd0);
    checkOutput("t6.ready", 32'(reqReady),    32'd0);
    checkOutput("t6.data",  32'(fifoDataIn),  32'd0);
    checkOutput("t6.gid",   32'(grantId),     32'd0);
    reqValid = 4'b0101;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expectCycle("t6.idle", 0, 8'h00, 4'b0000, 2'd0, 0, 0);
    expectCycle("t6.first", 1, 8'hA0, 4'b0001, 2'd0, 1, 0);
    reqValid = 4'b0000;
  endtask

  initial begin
    clk       = 1'b0;
    rst_n     = 1'b0;
    reqValid  = '0;
    fifoFull  = 1'b0;
    fifoError = 1'b0;
    errClr    = 1'b0;
    checks    = 0;
    errors    = 0;
    for (int i = 0; i < 4; i++) prodData[i] = '0;
    @(posedge clk);
    #1;
    applyStimulus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
